mem_arbiter: RTL and testbench

Two-requester memory arbiter that shares one memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the NPC core. It accepts one request at a time with round-robin priority, drives it onto the memory port with a valid/ready handshake, and routes the single response back to the originator. A watchdog ends any response wait longer than `TIMEOUT` cycles with an error response, so neither unit can hang.

---
 rtl/npc_bus_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/npc_bus_pkg.sv
// Shared types and default widths for the NPC memory bus arbiter slice.
package npc_bus_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between IFU, LSU, the arbiter and the memory port.
interface mem_arbiter_if
  import npc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic                ifu_req_valid;
  logic                ifu_req_ready;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_resp_valid;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                ifu_resp_err;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_resp_valid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                lsu_resp_err;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  // Requesters and memory model side
  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

  // Arbiter side
  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot grant, bit 0 = IFU, bit 1 = LSU.
module rr_arb2
  import npc_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == REQ_LSU) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: round-robin accept, registered
// issue, single routed response, watchdog error after TIMEOUT idle WAIT cycles.
module mem_arbiter
  import npc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned    CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e          state_q;
  req_id_e             owner_q;
  req_id_e             last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;

  logic [1:0]          gnt;
  logic                in_idle;
  logic                accept;
  logic                resp_fire;
  logic                resp_err;
  logic [DATA_W-1:0]   resp_data;

  rr_arb2 u_rr (
    .req_i  ({bus.lsu_req_valid, bus.ifu_req_valid}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // Ready depends only on state, pointer and the two valids
  assign in_idle           = (state_q == IDLE);
  assign bus.ifu_req_ready = in_idle & gnt[0];
  assign bus.lsu_req_ready = in_idle & gnt[1];
  assign accept            = in_idle & (|gnt);

  assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign resp_fire = (state_q == WAIT) & (bus.mem_resp_valid | (cnt_q == CNT_MAX));
  assign resp_err  = ~bus.mem_resp_valid;
  assign resp_data = bus.mem_resp_valid ? bus.mem_rdata : '0;

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  always_comb begin
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_rdata      = '0;
    bus.ifu_resp_err   = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_rdata      = '0;
    bus.lsu_resp_err   = 1'b0;
    if (resp_fire) begin
      if (owner_q == REQ_IFU) begin
        bus.ifu_resp_valid = 1'b1;
        bus.ifu_rdata      = resp_data;
        bus.ifu_resp_err   = resp_err;
      end else begin
        bus.lsu_resp_valid = 1'b1;
        bus.lsu_rdata      = resp_data;
        bus.lsu_resp_err   = resp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_q         <= REQ_IFU;
      last_q          <= REQ_LSU;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q         <= ISSUE;
            mem_req_valid_q <= 1'b1;
            if (gnt[0]) begin
              owner_q <= REQ_IFU;
              last_q  <= REQ_IFU;
              addr_q  <= bus.ifu_addr;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
            end else begin
              owner_q <= REQ_LSU;
              last_q  <= REQ_LSU;
              addr_q  <= bus.lsu_addr;
              wen_q   <= bus.lsu_wen;
              wdata_q <= bus.lsu_wdata;
              wmask_q <= bus.lsu_wmask;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            state_q         <= WAIT;
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
          end
        end
        WAIT: begin
          if (resp_fire) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checks of mem_arbiter against a transaction-level
// model: round-robin winner, issue payload, response routing and watchdog.
module tb_mem_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   last_g;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input int own, input bit ev,
                          input logic [31:0] erd, input bit eerr);
    chk({tag, "_ifu_rv"},  32'(b.ifu_resp_valid), 32'(ev && own == 0));
    chk({tag, "_ifu_rd"},  b.ifu_rdata, (ev && own == 0) ? erd : 32'h0);
    chk({tag, "_ifu_err"}, 32'(b.ifu_resp_err), 32'(ev && own == 0 && eerr));
    chk({tag, "_lsu_rv"},  32'(b.lsu_resp_valid), 32'(ev && own == 1));
    chk({tag, "_lsu_rd"},  b.lsu_rdata, (ev && own == 1) ? erd : 32'h0);
    chk({tag, "_lsu_err"}, 32'(b.lsu_resp_err), 32'(ev && own == 1 && eerr));
  endtask

  task automatic idle_inputs();
    b.ifu_req_valid  = 1'b0;
    b.ifu_addr       = '0;
    b.lsu_req_valid  = 1'b0;
    b.lsu_addr       = '0;
    b.lsu_wen        = 1'b0;
    b.lsu_wdata      = '0;
    b.lsu_wmask      = '0;
    b.mem_req_ready  = 1'b0;
    b.mem_resp_valid = 1'b0;
    b.mem_rdata      = '0;
  endtask

  task automatic junk_requests();
    b.ifu_req_valid = 1'($urandom);
    b.ifu_addr      = $urandom;
    b.lsu_req_valid = 1'($urandom);
    b.lsu_addr      = $urandom;
    b.lsu_wen       = 1'($urandom);
    b.lsu_wdata     = $urandom;
    b.lsu_wmask     = 4'($urandom);
  endtask

  // One full transaction starting in an IDLE cycle: accept, stall cycles of
  // ISSUE, then WAIT until the memory answers at cycle lat or the watchdog fires.
  task automatic xact(input bit iv, input bit lv, input logic [31:0] ia,
                      input logic [31:0] la, input bit w, input logic [31:0] wd,
                      input logic [3:0] wm, input int stall, input int lat,
                      input logic [31:0] rd);
    int          win;
    logic [31:0] ea;
    logic        ew;
    logic [3:0]  ewm;
    bit          done;
    win = (iv && lv) ? 1 - last_g : (iv ? 0 : 1);
    b.ifu_req_valid  = iv;
    b.ifu_addr       = ia;
    b.lsu_req_valid  = lv;
    b.lsu_addr       = la;
    b.lsu_wen        = w;
    b.lsu_wdata      = wd;
    b.lsu_wmask      = wm;
    b.mem_req_ready  = 1'($urandom);
    b.mem_resp_valid = 1'($urandom);
    b.mem_rdata      = $urandom;
    #1;
    chk("acc_ifu_ready", 32'(b.ifu_req_ready), 32'(win == 0));
    chk("acc_lsu_ready", 32'(b.lsu_req_ready), 32'(win == 1));
    chk("acc_mem_valid", 32'(b.mem_req_valid), 32'h0);
    chk_resp("acc", 0, 1'b0, 32'h0, 1'b0);
    last_g = win;
    ea  = (win == 0) ? ia : la;
    ew  = (win == 0) ? 1'b0 : w;
    ewm = (win == 0) ? 4'h0 : wm;
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      junk_requests();
      b.mem_req_ready  = (s == stall);
      b.mem_resp_valid = 1'($urandom);
      b.mem_rdata      = $urandom;
      #1;
      chk("iss_ifu_ready", 32'(b.ifu_req_ready), 32'h0);
      chk("iss_lsu_ready", 32'(b.lsu_req_ready), 32'h0);
      chk("iss_mem_valid", 32'(b.mem_req_valid), 32'h1);
      chk("iss_mem_addr",  b.mem_addr, ea);
      chk("iss_mem_wen",   32'(b.mem_wen), 32'(ew));
      chk("iss_mem_wmask", 32'(b.mem_wmask), 32'(ewm));
      if (win == 1) chk("iss_mem_wdata", b.mem_wdata, wd);
      chk_resp("iss", 0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
    end
    done = 1'b0;
    for (int k = 0; k <= TMO && !done; k++) begin
      junk_requests();
      b.mem_req_ready  = 1'($urandom);
      b.mem_resp_valid = (k == lat);
      b.mem_rdata      = (k == lat) ? rd : $urandom;
      #1;
      chk("wait_ifu_ready", 32'(b.ifu_req_ready), 32'h0);
      chk("wait_lsu_ready", 32'(b.lsu_req_ready), 32'h0);
      chk("wait_mem_valid", 32'(b.mem_req_valid), 32'h0);
      if (k == lat || k == TMO) begin
        chk_resp("resp", win, 1'b1, (k == lat) ? rd : 32'h0, k != lat);
        done = 1'b1;
      end else begin
        chk_resp("wait", 0, 1'b0, 32'h0, 1'b0);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    last_g = 1;
    b.mem_resp_valid = 1'b1;
    b.mem_rdata      = 32'h1234_5678;
    #1;
    chk("rst_mem_valid", 32'(b.mem_req_valid), 32'h0);
    chk("rst_mem_addr",  b.mem_addr, 32'h0);
    chk("rst_mem_wen",   32'(b.mem_wen), 32'h0);
    chk("rst_mem_wdata", b.mem_wdata, 32'h0);
    chk("rst_mem_wmask", 32'(b.mem_wmask), 32'h0);
    chk("rst_ifu_ready", 32'(b.ifu_req_ready), 32'h0);
    chk_resp("rst", 0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    idle_inputs();

    // Tie from reset: IFU, LSU, IFU
    xact(1, 1, 32'h8000_0100, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 0, 0, 32'hA1);
    xact(1, 1, 32'h8000_0104, 32'h8000_0204, 1'b1, 32'h55, 4'h3, 1, 2, 32'hA2);
    xact(1, 1, 32'h8000_0108, 32'h8000_0208, 1'b0, 32'h0, 4'h0, 0, 1, 32'hA3);

    // IFU fetch, immediate ready, response in first WAIT cycle
    xact(1, 0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0010_0093);

    // LSU write with four stall cycles
    xact(0, 1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 4, 1, 32'h0);

    // Watchdog, then late responses must be dropped
    xact(1, 0, 32'h8000_0010, 32'h0, 1'b0, 32'h0, 4'h0, 0, TMO + 5, 32'h0);
    for (int i = 0; i < 2; i++) begin
      b.mem_resp_valid = 1'b1;
      b.mem_rdata      = 32'hBAD0_0000;
      #1;
      chk("late_ifu_ready", 32'(b.ifu_req_ready), 32'h0);
      chk_resp("late", 0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
    end
    idle_inputs();

    // Reset while in WAIT drops the transaction
    b.ifu_req_valid = 1'b1;
    b.ifu_addr      = 32'h8000_0040;
    #1;
    chk("rw_acc_ready", 32'(b.ifu_req_ready), 32'h1);
    @(negedge clk);
    b.ifu_req_valid = 1'b0;
    b.mem_req_ready = 1'b1;
    #1;
    chk("rw_iss_valid", 32'(b.mem_req_valid), 32'h1);
    @(negedge clk);
    b.mem_req_ready = 1'b0;
    #1;
    chk_resp("rw_wait", 0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_resp("rw_rst", 0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset  = 1'b0;
    last_g = 1;
    b.mem_resp_valid = 1'b1;
    b.mem_rdata      = 32'hCAFE_F00D;
    #1;
    chk("rw_post_valid", 32'(b.mem_req_valid), 32'h0);
    chk("rw_post_ready", 32'(b.ifu_req_ready), 32'h0);
    chk_resp("rw_post", 0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    idle_inputs();
    xact(1, 1, 32'h8000_0080, 32'h8000_0300, 1'b1, 32'h77, 4'h1, 1, 3, 32'h0000_0013);

    for (int n = 0; n < 80; n++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      xact(sel[0], sel[1], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
           int'($urandom_range(0, 3)), int'($urandom_range(0, TMO + 3)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
